panel_keys: RTL and testbench

- Parametrised front-panel switch controller on an Avalon-MM slave.
- Generalises the operator/maintenance panel register block: configurable key count, per-key latching or momentary (auto-release) mode, N data-switch words of configurable width.
- Adds synchronised, debounced external switch inputs with sticky change flags and an interrupt line.
- Sits between the host bus and the processor's key/data-switch inputs.

---
 rtl/panel_keys.sv | 200 ++++++++++++++++++++
 tb/tb_panel_keys.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_keys.sv
// Front-panel switch controller: key outputs (latching or momentary), data-switch
// words, and debounced external switches with sticky change flags, on an Avalon-MM slave.
module panel_keys #(
   parameter int unsigned NKEYS        = 20,
   parameter logic [31:0] MOMENTARY    = 32'h000003FF,
   parameter logic [31:0] KEY_RESET    = 32'h0,
   parameter int unsigned PULSE_CYCLES = 1000,
   parameter int unsigned NEXT         = 4,
   parameter int unsigned DEBOUNCE     = 50000,
   parameter int unsigned NWORDS       = 3,
   parameter int unsigned WIDTH        = 18
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [5:0]              s_address,
   input  logic                    s_write,
   input  logic                    s_read,
   input  logic [31:0]             s_writedata,
   output logic [31:0]             s_readdata,
   output logic                    s_readdatavalid,
   output logic                    s_waitrequest,
   output logic [NKEYS-1:0]        keys,
   output logic [NWORDS*WIDTH-1:0] data_sw,
   input  logic [NEXT-1:0]         ext_in,
   output logic [NEXT-1:0]         ext_sw,
   output logic                    ext_irq
);

   // Bus handshake: the slave never stalls; a read strobe sampled at a rising edge
   // is answered by s_readdatavalid high for exactly the following cycle.

   localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES + 1) : 1;
   localparam int unsigned DW = $clog2(DEBOUNCE + 1);

   localparam logic [5:0] A_KEYSET = 6'd0;
   localparam logic [5:0] A_KEYCLR = 6'd1;
   localparam logic [5:0] A_MODE   = 6'd2;
   localparam logic [5:0] A_EXT    = 6'd3;
   localparam logic [5:0] A_EXTCHG = 6'd4;
   localparam int unsigned A_DATA0 = 5;

   logic wr_keyset;
   logic wr_keyclr;
   logic wr_extchg;

   assign wr_keyset = s_write && (s_address == A_KEYSET);
   assign wr_keyclr = s_write && (s_address == A_KEYCLR);
   assign wr_extchg = s_write && (s_address == A_EXTCHG);

   // Writes only use the low bits of s_writedata; the rest is intentionally dropped.
   logic unused_wdata;
   assign unused_wdata = ^s_writedata;

   assign s_waitrequest = 1'b0;

   // ------------------------------------------------------------------ keys
   logic [NKEYS-1:0] active;

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      if (MOMENTARY[i]) begin : g_mom
         // The key level is the counter being nonzero, so a retrigger never dips low.
         logic [PW-1:0] cnt;

         always_ff @(posedge clk) begin
            if (!reset) begin
               cnt <= '0;
            end else if (wr_keyclr && s_writedata[i]) begin
               cnt <= '0;
            end else if (wr_keyset && s_writedata[i]) begin
               cnt <= PW'(PULSE_CYCLES);
            end else if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end
         end

         assign keys[i]   = (cnt != '0);
         assign active[i] = (cnt != '0);
      end else begin : g_lat
         logic lat;

         always_ff @(posedge clk) begin
            if (!reset) begin
               lat <= KEY_RESET[i];
            end else if (wr_keyclr && s_writedata[i]) begin
               lat <= 1'b0;
            end else if (wr_keyset && s_writedata[i]) begin
               lat <= 1'b1;
            end
         end

         assign keys[i]   = lat;
         assign active[i] = 1'b0;
      end
   end

   // ------------------------------------------------------------------ data words
   logic [WIDTH-1:0] dw [NWORDS];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < NWORDS; k++) begin
            dw[k] <= '0;
         end
      end else if (s_write) begin
         for (int k = 0; k < NWORDS; k++) begin
            if (s_address == 6'(A_DATA0 + k)) begin
               dw[k] <= s_writedata[WIDTH-1:0];
            end
         end
      end
   end

   for (genvar k = 0; k < NWORDS; k++) begin : g_dsw
      assign data_sw[k*WIDTH +: WIDTH] = dw[k];
   end

   // ------------------------------------------------------------------ external switches
   logic [NEXT-1:0] sync1;
   logic [NEXT-1:0] sync2;
   logic [NEXT-1:0] ext_q;
   logic [NEXT-1:0] sticky;
   logic [NEXT-1:0] accept;
   logic [NEXT-1:0] chg_clr;
   logic [DW-1:0]   dcnt [NEXT];

   // Acceptance happens on the edge after the counter reaches DEBOUNCE, which makes a
   // clean step appear 2+DEBOUNCE edges after the edge that first samples it.
   always_comb begin
      accept = '0;
      for (int j = 0; j < NEXT; j++) begin
         accept[j] = (sync2[j] != ext_q[j]) && (dcnt[j] == DW'(DEBOUNCE));
      end
   end

   assign chg_clr = wr_extchg ? s_writedata[NEXT-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         ext_q  <= '0;
         sticky <= '0;
         for (int j = 0; j < NEXT; j++) begin
            dcnt[j] <= '0;
         end
      end else begin
         sync1 <= ext_in;
         sync2 <= sync1;
         for (int j = 0; j < NEXT; j++) begin
            if (sync2[j] == ext_q[j]) begin
               dcnt[j] <= '0;
            end else if (accept[j]) begin
               dcnt[j]  <= '0;
               ext_q[j] <= sync2[j];
            end else begin
               dcnt[j] <= dcnt[j] + 1'b1;
            end
         end
         // A new change outranks a same-cycle write-1-to-clear.
         sticky <= (sticky & ~chg_clr) | accept;
      end
   end

   assign ext_sw  = ext_q;
   assign ext_irq = |sticky;

   // ------------------------------------------------------------------ read path
   logic [31:0] rd_val;

   always_comb begin
      rd_val = '0;
      case (s_address)
         A_KEYSET: rd_val[NKEYS-1:0] = keys;
         A_KEYCLR: rd_val[NKEYS-1:0] = active;
         A_MODE:   rd_val[NKEYS-1:0] = MOMENTARY[NKEYS-1:0];
         A_EXT:    rd_val[NEXT-1:0]  = ext_q;
         A_EXTCHG: rd_val[NEXT-1:0]  = sticky;
         default: begin
            for (int k = 0; k < NWORDS; k++) begin
               if (s_address == 6'(A_DATA0 + k)) begin
                  rd_val[WIDTH-1:0] = dw[k];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s_readdata      <= '0;
         s_readdatavalid <= 1'b0;
      end else begin
         s_readdatavalid <= s_read;
         if (s_read) begin
            s_readdata <= rd_val;
         end
      end
   end

endmodule

// File: tb/tb_panel_keys.sv
// Self-checking bench for panel_keys: directed scenarios plus randomized traffic,
// all compared against a timestamp/window based reference model.
module tb_panel_keys;

   localparam int NKEYS  = 20;
   localparam int NEXT   = 4;
   localparam int NWORDS = 3;
   localparam int WIDTH  = 18;
   localparam int P      = 5;
   localparam int D      = 4;
   localparam logic [31:0] MOM  = 32'h000003FF;
   localparam logic [31:0] KRST = 32'h00000400;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [5:0]              s_address;
   logic                    s_write;
   logic                    s_read;
   logic [31:0]             s_writedata;
   logic [31:0]             s_readdata;
   logic                    s_readdatavalid;
   logic                    s_waitrequest;
   logic [NKEYS-1:0]        keys;
   logic [NWORDS*WIDTH-1:0] data_sw;
   logic [NEXT-1:0]         ext_in;
   logic [NEXT-1:0]         ext_sw;
   logic                    ext_irq;

   always #5 clk = ~clk;

   panel_keys #(
      .NKEYS(NKEYS), .MOMENTARY(MOM), .KEY_RESET(KRST), .PULSE_CYCLES(P),
      .NEXT(NEXT), .DEBOUNCE(D), .NWORDS(NWORDS), .WIDTH(WIDTH)
   ) dut (
      .clk(clk), .reset(reset), .s_address(s_address), .s_write(s_write),
      .s_read(s_read), .s_writedata(s_writedata), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid), .s_waitrequest(s_waitrequest),
      .keys(keys), .data_sw(data_sw), .ext_in(ext_in), .ext_sw(ext_sw),
      .ext_irq(ext_irq)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model
   int               cyc;
   int               exp_t [NKEYS];     // momentary key is high while cyc < exp_t
   logic [NKEYS-1:0] lat_m;
   logic [WIDTH-1:0] dw_m [NWORDS];
   logic [NEXT-1:0]  ext_m;
   logic [NEXT-1:0]  sticky_m;
   logic [NEXT-1:0]  hist [$];          // raw samples, oldest first, D+3 deep
   logic             rv_m;
   logic [31:0]      exp_q [$];

   function automatic logic [NKEYS-1:0] keys_m();
      logic [NKEYS-1:0] k;
      for (int i = 0; i < NKEYS; i++) k[i] = MOM[i] ? (cyc < exp_t[i]) : lat_m[i];
      return k;
   endfunction

   function automatic logic [NKEYS-1:0] active_m();
      logic [NKEYS-1:0] k;
      for (int i = 0; i < NKEYS; i++) k[i] = MOM[i] && (cyc < exp_t[i]);
      return k;
   endfunction

   function automatic logic [NWORDS*WIDTH-1:0] dsw_m();
      logic [NWORDS*WIDTH-1:0] r;
      for (int k = 0; k < NWORDS; k++) r[k*WIDTH +: WIDTH] = dw_m[k];
      return r;
   endfunction

   function automatic logic [31:0] read_m(input int a);
      logic [31:0] r;
      r = '0;
      if (a == 0) r[NKEYS-1:0] = keys_m();
      else if (a == 1) r[NKEYS-1:0] = active_m();
      else if (a == 2) r[NKEYS-1:0] = MOM[NKEYS-1:0];
      else if (a == 3) r[NEXT-1:0] = ext_m;
      else if (a == 4) r[NEXT-1:0] = sticky_m;
      else if (a >= 5 && a < 5 + NWORDS) r[WIDTH-1:0] = dw_m[a-5];
      return r;
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < NKEYS; i++) exp_t[i] = 0;
      lat_m    = KRST[NKEYS-1:0];
      for (int k = 0; k < NWORDS; k++) dw_m[k] = '0;
      ext_m    = '0;
      sticky_m = '0;
      hist.delete();
      for (int i = 0; i < D + 3; i++) hist.push_back('0);
      exp_q.delete();
      rv_m = 1'b0;
   endtask

   task automatic model_edge(input logic wr, input int a, input logic [31:0] wd,
                             input logic rd, input logic [NEXT-1:0] ei);
      logic [NEXT-1:0] flip;
      logic [NEXT-1:0] clr;
      if (rd) exp_q.push_back(read_m(a));
      rv_m = rd;
      cyc++;
      for (int i = 0; i < NKEYS; i++) begin
         if (wr && a == 0 && wd[i]) begin
            if (MOM[i]) exp_t[i] = cyc + P;
            else lat_m[i] = 1'b1;
         end
         if (wr && a == 1 && wd[i]) begin
            if (MOM[i]) exp_t[i] = cyc;
            else lat_m[i] = 1'b0;
         end
      end
      if (wr && a >= 5 && a < 5 + NWORDS) dw_m[a-5] = wd[WIDTH-1:0];
      // A switch flips once the D+1 synchronised samples ending two edges ago all disagree.
      hist.push_back(ei);
      void'(hist.pop_front());
      flip = '0;
      for (int j = 0; j < NEXT; j++) begin
         flip[j] = 1'b1;
         for (int w = 0; w <= D; w++) if (hist[w][j] == ext_m[j]) flip[j] = 1'b0;
      end
      ext_m    = ext_m ^ flip;
      clr      = (wr && a == 4) ? wd[NEXT-1:0] : '0;
      sticky_m = (sticky_m & ~clr) | flip;
   endtask

   task automatic compare();
      logic [31:0] e;
      check_eq("keys", 64'(keys), 64'(keys_m()));
      check_eq("data_sw", 64'(data_sw), 64'(dsw_m()));
      check_eq("ext_sw", 64'(ext_sw), 64'(ext_m));
      check_eq("ext_irq", 64'(ext_irq), 64'(|sticky_m));
      check_eq("rvalid", 64'(s_readdatavalid), 64'(rv_m));
      check_eq("waitreq", 64'(s_waitrequest), 64'h0);
      if (rv_m && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("rdata", 64'(s_readdata), 64'(e));
      end
   endtask

   // ---------------- driver: one clock per call, inputs applied at the falling edge
   logic [NEXT-1:0] ext_cur;

   task automatic step(input logic rst_n, input logic wr, input int a,
                       input logic [31:0] wd, input logic rd);
      reset       = rst_n;
      s_write     = wr;
      s_address   = 6'(a);
      s_writedata = wd;
      s_read      = rd;
      ext_in      = ext_cur;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge(wr, a, wd, rd, ext_cur);
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 32'h0, 1'b0);
   endtask

   int n;

   initial begin
      ext_cur = '0;
      model_reset();
      @(negedge clk);

      // reset
      step(1'b0, 1'b0, 0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 0, 32'h0, 1'b0);
      check_eq("rst_keys", 64'(keys), 64'h00400);
      check_eq("rst_data_sw", 64'(data_sw), 64'h0);
      check_eq("rst_ext_sw", 64'(ext_sw), 64'h0);
      check_eq("rst_ext_irq", 64'(ext_irq), 64'h0);
      check_eq("rst_rdata", 64'(s_readdata), 64'h0);
      step(1'b1, 1'b0, 0, 32'h0, 1'b1);
      check_eq("rst_read0", 64'(s_readdata), 64'h400);

      // momentary pulse
      step(1'b1, 1'b1, 0, 32'h1, 1'b0);
      n = int'(keys[0]);
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b0, 1, 32'h0, i == 1);
         if (i == 1) check_eq("pulse_active", 64'(s_readdata), 64'h1);
         n += int'(keys[0]);
      end
      check_eq("pulse_len", 64'(n), 64'd5);
      step(1'b1, 1'b0, 1, 32'h0, 1'b1);
      check_eq("active_after", 64'(s_readdata), 64'h0);

      // retrigger
      step(1'b1, 1'b1, 0, 32'h1, 1'b0);
      n = int'(keys[0]);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 0, 32'h0, 1'b0);
         n += int'(keys[0]);
      end
      step(1'b1, 1'b1, 0, 32'h1, 1'b0);
      n += int'(keys[0]);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 0, 32'h0, 1'b0);
         n += int'(keys[0]);
      end
      check_eq("retrig_len", 64'(n), 64'd8);

      // clear a momentary key mid-pulse
      step(1'b1, 1'b1, 0, 32'h8, 1'b0);
      step(1'b1, 1'b0, 0, 32'h0, 1'b0);
      check_eq("key3_high", 64'(keys[3]), 64'h1);
      step(1'b1, 1'b1, 1, 32'h8, 1'b0);
      check_eq("key3_clr", 64'(keys[3]), 64'h0);

      // latching key with same-cycle read
      step(1'b1, 1'b1, 0, 32'h800, 1'b1);
      check_eq("lat_old_read", 64'(s_readdata[11]), 64'h0);
      idle(20);
      check_eq("lat_hold", 64'(keys[11]), 64'h1);
      step(1'b1, 1'b1, 1, 32'h800, 1'b0);
      check_eq("lat_clr", 64'(keys[11]), 64'h0);

      // data words
      step(1'b1, 1'b1, 5, 32'h3FFFF, 1'b0);
      step(1'b1, 1'b1, 7, 32'h12345, 1'b0);
      check_eq("dsw_pack", 64'(data_sw), 64'({18'h12345, 18'h0, 18'h3FFFF}));
      step(1'b1, 1'b0, 7, 32'h0, 1'b1);
      check_eq("dsw_rd7", 64'(s_readdata), 64'h12345);
      step(1'b1, 1'b1, 6, 32'hFFFFFFFF, 1'b0);
      step(1'b1, 1'b0, 6, 32'h0, 1'b1);
      check_eq("dsw_rd6", 64'(s_readdata), 64'h3FFFF);

      // reset mid-pulse
      step(1'b1, 1'b1, 0, 32'h1, 1'b0);
      step(1'b0, 1'b0, 0, 32'h0, 1'b0);
      check_eq("rst_mid_pulse", 64'(keys), 64'h00400);

      // debounce step: rises 2+D edges after the sampling edge (7th call)
      ext_cur = 4'b0100;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 1'b0, 0, 32'h0, 1'b0);
         if (n == 0 && ext_sw[2]) n = i;
      end
      check_eq("deb_latency", 64'(n), 64'd7);
      step(1'b1, 1'b0, 4, 32'h0, 1'b1);
      check_eq("extchg_rd", 64'(s_readdata), 64'h4);
      check_eq("irq_set", 64'(ext_irq), 64'h1);

      // short glitch rejected
      ext_cur = 4'b0110;
      idle(3);
      ext_cur = 4'b0100;
      idle(12);
      check_eq("glitch_rej", 64'(ext_sw), 64'h4);
      step(1'b1, 1'b1, 4, 32'h4, 1'b0);
      check_eq("irq_clr", 64'(ext_irq), 64'h0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         logic wr, rd, rs;
         int a;
         for (int j = 0; j < NEXT; j++) if ($urandom_range(0, 5) == 0) ext_cur[j] = ~ext_cur[j];
         rs = ($urandom_range(0, 199) != 0);
         wr = ($urandom_range(0, 3) == 0);
         rd = 1'(($urandom_range(0, 1)));
         a  = $urandom_range(0, 9);
         if (a == 9) a = $urandom_range(8, 63);
         step(rs, wr, a, $urandom, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
